distortion_clip_stage: RTL and testbench

//  Sample-processing stage between the input sample FIFO (Avalon write side) and the output sample FIFO
//  (Avalon read side) of the guitar effect path, clocked on the sample clock. Pops one signed sample,

---
 rtl/distortion_clip_stage.sv | 153 +++++++++++++++
 tb/tb_distortion_clip_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/distortion_clip_stage.sv
// Guitar-path distortion stage: pops one sample, applies fixed-point gain,
// hard-clips symmetrically at the boost threshold and pushes the result.
module distortion_clip_stage #(
    parameter int DATA_W    = 32,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bypass,
    input  logic [GAIN_W-1:0] gain,
    input  logic [DATA_W-1:0] boost,
    input  logic              clear_count,
    input  logic              in_empty,
    output logic              in_rdreq,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_full,
    output logic              out_wrreq,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              clip_flag,
    output logic [CNT_W-1:0]  clip_count
);

    localparam int                PROD_W  = DATA_W + GAIN_W + 1;
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LATCH, S_MULT, S_CLIP, S_WRITE
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_W-1:0]         data_h_q, data_h_d;
    logic                      bypass_h_q, bypass_h_d;
    logic [GAIN_W-1:0]         gain_h_q, gain_h_d;
    logic [DATA_W-1:0]         boost_h_q, boost_h_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;
    logic                      clipped_q, clipped_d;
    logic                      clip_flag_q, clip_flag_d;
    logic [CNT_W-1:0]          clip_count_q, clip_count_d;

    logic signed [PROD_W-1:0]  data_ext, gain_ext, scaled, thr_ext;
    logic [DATA_W-1:0]         thr;

    // Operands widened to the full product width so the multiply cannot overflow.
    always_comb begin
        data_ext = {{(PROD_W-DATA_W){data_h_q[DATA_W-1]}}, data_h_q};
        gain_ext = {{(PROD_W-GAIN_W){1'b0}}, gain_h_q};
        scaled   = prod_q >>> GAIN_FRAC;
        thr      = (boost_h_q == '0 || boost_h_q > MAX_POS) ? MAX_POS : boost_h_q;
        thr_ext  = {{(PROD_W-DATA_W){1'b0}}, thr};
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d      = state_q;
        data_h_d     = data_h_q;
        bypass_h_d   = bypass_h_q;
        gain_h_d     = gain_h_q;
        boost_h_d    = boost_h_q;
        prod_d       = prod_q;
        out_data_d   = out_data_q;
        clipped_d    = clipped_q;
        clip_flag_d  = clip_flag_q;
        clip_count_d = clip_count_q;
        in_rdreq     = 1'b0;
        out_wrreq    = 1'b0;

        case (state_q)
            S_IDLE: if (!in_empty) state_d = S_READ;
            S_READ: begin
                in_rdreq = 1'b1;
                state_d  = S_LATCH;
            end
            S_LATCH: begin
                data_h_d   = in_data;
                bypass_h_d = bypass;
                gain_h_d   = gain;
                boost_h_d  = boost;
                state_d    = S_MULT;
            end
            S_MULT: begin
                prod_d  = data_ext * gain_ext;
                state_d = S_CLIP;
            end
            S_CLIP: begin
                if (bypass_h_q) begin
                    out_data_d = data_h_q;
                    clipped_d  = 1'b0;
                end else if (scaled > thr_ext) begin
                    out_data_d = thr;
                    clipped_d  = 1'b1;
                end else if (scaled < -thr_ext) begin
                    out_data_d = -thr;
                    clipped_d  = 1'b1;
                end else begin
                    out_data_d = scaled[DATA_W-1:0];
                    clipped_d  = 1'b0;
                end
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (!out_full) begin
                    out_wrreq   = 1'b1;
                    clip_flag_d = clipped_q;
                    if (clipped_q && clip_count_q != '1)
                        clip_count_d = clip_count_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear has priority over an increment landing in the same cycle.
        if (clear_count) clip_count_d = '0;
    end

    // NOTE: holding registers are reset too, so a sample cut off by reset leaves no stale data behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            data_h_q     <= '0;
            bypass_h_q   <= 1'b0;
            gain_h_q     <= '0;
            boost_h_q    <= '0;
            prod_q       <= '0;
            out_data_q   <= '0;
            clipped_q    <= 1'b0;
            clip_flag_q  <= 1'b0;
            clip_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees the pre-edge values.
            state_q      <= state_d;
            data_h_q     <= data_h_d;
            bypass_h_q   <= bypass_h_d;
            gain_h_q     <= gain_h_d;
            boost_h_q    <= boost_h_d;
            prod_q       <= prod_d;
            out_data_q   <= out_data_d;
            clipped_q    <= clipped_d;
            clip_flag_q  <= clip_flag_d;
            clip_count_q <= clip_count_d;
        end
    end

    assign out_data   = out_data_q;
    assign busy       = (state_q != S_IDLE);
    assign clip_flag  = clip_flag_q;
    assign clip_count = clip_count_q;

endmodule

// File: tb/tb_distortion_clip_stage.sv
// Bench for distortion_clip_stage: FIFO models around the DUT, a scoreboard of
// expected samples/flags filled at push time and drained on each write request.
module tb_distortion_clip_stage;

    localparam int                DATA_W  = 32;
    localparam int                GAIN_W  = 16;
    localparam int                CNT_W   = 8;
    localparam logic [DATA_W-1:0] MAX_POS = 32'h7FFF_FFFF;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              bypass = 1'b0;
    logic [GAIN_W-1:0] gain = '0;
    logic [DATA_W-1:0] boost = '0;
    logic              clear_count = 1'b0;
    logic              in_empty = 1'b1;
    logic              in_rdreq;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_full = 1'b0;
    logic              out_wrreq;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              clip_flag;
    logic [CNT_W-1:0]  clip_count;

    distortion_clip_stage #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .GAIN_FRAC(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bypass(bypass), .gain(gain), .boost(boost),
        .clear_count(clear_count), .in_empty(in_empty), .in_rdreq(in_rdreq),
        .in_data(in_data), .out_full(out_full), .out_wrreq(out_wrreq),
        .out_data(out_data), .busy(busy), .clip_flag(clip_flag), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0, n_rd = 0, n_wr = 0, rd_cyc = 0, last_lat = 0;
    logic [DATA_W-1:0] in_fifo[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              flag_q[$];
    logic [DATA_W-1:0] cur = '0;
    logic              rd_pending = 1'b0, chk_flag = 1'b0, exp_flag_now = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: gain in Q8.8, floor shift, symmetric clip at min(boost, max positive).
    task automatic model(input logic [DATA_W-1:0] x, output logic [DATA_W-1:0] y, output logic c);
        longint s, lim;
        if (bypass) begin
            y = x;
            c = 1'b0;
        end else begin
            s   = (longint'($signed(x)) * longint'(gain)) >>> 8;
            lim = (boost == 0 || boost > MAX_POS) ? longint'(MAX_POS) : longint'(boost);
            if (s > lim) begin
                y = 32'(lim);  c = 1'b1;
            end else if (s < -lim) begin
                y = 32'(-lim); c = 1'b1;
            end else begin
                y = 32'(s);    c = 1'b0;
            end
        end
    endtask

    task automatic put(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] y;
        logic c;
        model(x, y, c);
        in_fifo.push_back(x);
        exp_q.push_back(y);
        flag_q.push_back(c);
    endtask

    task automatic drain(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0 && in_fifo.size() == 0 && !busy) break;
            @(posedge clk); #1;
        end
        check(tag, exp_q.size(), 0);
        @(negedge clk); #1;
    endtask

    task automatic wait_read(input string tag);
        int base;
        base = n_rd;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (n_rd != base) break;
        end
        check(tag, (n_rd != base), 1);
    endtask

    // Input FIFO (non-showahead), output FIFO sink and scoreboard compare.
    always @(negedge clk) begin
        cyc++;
        if (chk_flag) begin
            check("clip_flag", clip_flag, exp_flag_now);
            chk_flag = 1'b0;
        end
        if (in_rdreq) begin
            n_rd++;
            rd_cyc = cyc;
            check("rd_while_empty", in_empty, 0);
            if (in_fifo.size() != 0) cur = in_fifo.pop_front();
            rd_pending = 1'b1;
            in_data    = $urandom;
        end else if (rd_pending) begin
            in_data    = cur;
            rd_pending = 1'b0;
        end else begin
            in_data = $urandom;
        end
        if (out_wrreq) begin
            n_wr++;
            last_lat = cyc - rd_cyc;
            check("wr_while_full", out_full, 0);
            check("wr_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("out_data", out_data, exp_q.pop_front());
                exp_flag_now = flag_q.pop_front();
                chk_flag     = 1'b1;
            end
        end
        in_empty = (in_fifo.size() == 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wrs, rds;
        #1;
        check("rst_rdreq", in_rdreq, 0);
        check("rst_wrreq", out_wrreq, 0);
        check("rst_busy", busy, 0);
        check("rst_flag", clip_flag, 0);
        check("rst_out_data", out_data, 0);
        check("rst_count", clip_count, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // T1: bypass forwards exactly, 4-clock read-to-write latency
        bypass = 1'b1; gain = 16'h0000; boost = '0;
        put(32'h0000_1234);
        drain("t1_drain", 60);
        check("t1_latency", last_lat, 4);
        check("t1_count", clip_count, 0);

        // T2: gain 2.0, clipping disabled
        bypass = 1'b0; gain = 16'h0200; boost = '0;
        put(32'd1000);
        put(-32'sd1000);
        drain("t2_drain", 60);
        check("t2_count", clip_count, 0);

        // Arithmetic shift floors toward minus infinity: gain 1.5
        gain = 16'h0180;
        put(-32'sd3);
        put(32'd5);
        drain("floor_drain", 60);

        // T3: gain 2.0, threshold 1500
        gain = 16'h0200; boost = 32'd1500;
        put(32'd1000);
        put(-32'sd1000);
        put(32'd700);
        drain("t3_drain", 80);
        check("t3_count", clip_count, 2);
        check("t3_flag", clip_flag, 0);

        // Controls changed after LATCH must not affect the sample in flight
        put(32'd600);
        wait_read("ctl_wait_rd");
        @(posedge clk); #1;
        gain = 16'h0400; boost = 32'd5;
        drain("ctl_drain", 60);
        check("ctl_count", clip_count, 2);
        gain = 16'h0200; boost = 32'd1500;

        // T4: maximum gain saturates to the DATA_W extremes
        gain = 16'hFFFF; boost = '0;
        put(32'h4000_0000);
        put(32'hC000_0000);
        drain("t4_drain", 60);
        check("t4_count", clip_count, 4);

        // T5: output back-pressure, then idle with an empty input FIFO
        gain = 16'h0100; boost = '0; out_full = 1'b1;
        wrs = n_wr;
        put(32'h0BAD_F00D);
        repeat (15) @(posedge clk);
        #1;
        check("t5_no_wr", n_wr - wrs, 0);
        check("t5_hold_data", out_data, 32'h0BAD_F00D);
        check("t5_busy", busy, 1);
        repeat (10) @(posedge clk);
        #1;
        check("t5_stable", out_data, 32'h0BAD_F00D);
        out_full = 1'b0;
        drain("t5_drain", 40);
        check("t5_one_wr", n_wr - wrs, 1);
        rds = n_rd;
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_rd", n_rd - rds, 0);
        check("t5_idle", busy, 0);

        // T6a: reset while the sample is in MULT drops it
        put(32'h0000_0055);
        wait_read("t6_wait_rd");
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_wrreq", out_wrreq, 0);
        check("t6_out_data", out_data, 0);
        check("t6_count", clip_count, 0);
        check("t6_rdreq", in_rdreq, 0);
        exp_q.delete();
        flag_q.delete();
        @(negedge clk);
        reset = 1'b1;
        wrs = n_wr;
        repeat (12) @(posedge clk);
        #1;
        check("t6_no_wr", n_wr - wrs, 0);

        // T6b: counter saturates at all-ones under a stream of clipped samples
        gain = 16'h0100; boost = 32'd100;
        for (int i = 0; i < 260; i++) put(32'd1000);
        drain("sat_drain", 1800);
        check("sat_count", clip_count, {CNT_W{1'b1}});
        check("sat_flag", clip_flag, 1);

        // T6c: clear in the same cycle as a clipped write wins
        put(32'd1000);
        wait_read("clr_wait_rd");
        repeat (3) @(posedge clk);
        #1;
        clear_count = 1'b1;
        @(posedge clk); #1;
        clear_count = 1'b0;
        check("clr_count", clip_count, 0);
        drain("clr_drain", 40);
        check("clr_count_after", clip_count, 0);

        // A later clipped sample counts from zero again
        put(-32'sd1000);
        drain("recount_drain", 40);
        check("recount", clip_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
